// File: rtl/run_control_pkg.sv
// Shared definitions for the run-control slice: FSM state encodings,
// press priorities, default timing parameters and the HLT opcode that
// decode also uses. Optional feature macro: BREAKPOINT_EN (see top).
package run_control_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } run_state_e;

  // Numeric order follows arbitration priority (higher wins).
  typedef enum logic [2:0] {
    PR_NONE    = 3'd0,
    PR_RUN     = 3'd1,
    PR_STEP    = 3'd2,
    PR_STOP    = 3'd3,
    PR_RESTART = 3'd4
  } press_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_STEP_CYCLES     = 1;
  localparam logic [7:0]  HLT_OPCODE              = 8'h76;

  // Only the highest-priority press of a cycle survives.
  function automatic press_e pick_press(input logic restart, input logic stop,
                                        input logic step, input logic run);
    press_e sel;
    if (restart)   sel = PR_RESTART;
    else if (stop) sel = PR_STOP;
    else if (step) sel = PR_STEP;
    else if (run)  sel = PR_RUN;
    else           sel = PR_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw asynchronous button: 2-flop synchronizer, stability
// counter, and a registered one-cycle press on the debounced rising edge.
module button_debouncer
  import run_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, accept a new level after DEBOUNCE_CYCLES disagreeing samples, detect rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      synced  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      meta    <= raw;
      synced  <= meta;
      if (synced != level) begin
        if (cnt == LAST) begin
          level <= synced;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/run_control_unit.sv
// Run/stop/step/restart sequencing for the 8-bit core, feeding the
// two-phase clock controller. Define BREAKPOINT_EN to add the PC
// breakpoint ports and halt logic.
module run_control_unit
  import run_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STEP_CYCLES     = DEFAULT_STEP_CYCLES
) (
  input  logic       internal_clock,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_stop,
  input  logic       btn_step,
  input  logic       btn_restart,
  input  logic       hlt_decoded,
  output logic       controller_enable,
  output logic       halted,
  output logic       resume,
  output logic       restart,
  output logic [1:0] run_state
`ifdef BREAKPOINT_EN
  ,
  input  logic       bp_enable,
  input  logic [7:0] bp_addr,
  input  logic [7:0] pc
`endif
);

  localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES);

  logic          press_run;
  logic          press_stop;
  logic          press_step;
  logic          press_restart;
  press_e        sel;
  run_state_e    state;
  run_state_e    state_next;
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] step_cnt_next;
  logic          bp_hit;
  logic          halt_evt;
  logic          ce_next;
  logic          halted_next;
  logic          resume_next;
  logic          restart_next;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(internal_clock), .rst_n(reset), .raw(btn_run), .press(press_run)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk(internal_clock), .rst_n(reset), .raw(btn_stop), .press(press_stop)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(internal_clock), .rst_n(reset), .raw(btn_step), .press(press_step)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_restart (
    .clk(internal_clock), .rst_n(reset), .raw(btn_restart), .press(press_restart)
  );

  assign sel = pick_press(press_restart, press_stop, press_step, press_run);

`ifdef BREAKPOINT_EN
  logic bp_mask;

  // Mask the breakpoint for the first cycle after a run press enters RUN,
  // so the core can step off the breakpoint address.
  always_ff @(posedge internal_clock or negedge reset) begin
    if (!reset) bp_mask <= 1'b0;
    else        bp_mask <= (state_next == ST_RUN) && (state != ST_RUN) && (sel == PR_RUN);
  end

  assign bp_hit = bp_enable && (pc == bp_addr) && !bp_mask;
`else
  assign bp_hit = 1'b0;
`endif

  assign halt_evt  = hlt_decoded | bp_hit;
  assign run_state = state;

  // State, step counter and registered outputs.
  always_ff @(posedge internal_clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_OFF;
      step_cnt          <= '0;
      controller_enable <= 1'b0;
      halted            <= 1'b0;
      resume            <= 1'b0;
      restart           <= 1'b0;
    end else begin
      state             <= state_next;
      step_cnt          <= step_cnt_next;
      controller_enable <= ce_next;
      halted            <= halted_next;
      resume            <= resume_next;
      restart           <= restart_next;
    end
  end

  // Next-state and step-counter logic.
  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    case (state)
      ST_OFF: begin
        if (sel == PR_RESTART || sel == PR_RUN) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (sel == PR_RESTART)                    state_next = ST_RUN;
        else if (sel == PR_STOP || halt_evt)      state_next = ST_HALT;
      end
      ST_HALT: begin
        if (sel == PR_RESTART || sel == PR_RUN) begin
          state_next = ST_RUN;
        end else if (sel == PR_STEP) begin
          state_next    = ST_STEP;
          step_cnt_next = STEP_LOAD;
        end
      end
      ST_STEP: begin
        // The step expires on the edge where the counter reaches 0.
        step_cnt_next = step_cnt - 1'b1;
        if (sel == PR_RESTART) begin
          state_next    = ST_RUN;
          step_cnt_next = '0;
        end else if (sel == PR_STOP || halt_evt || step_cnt <= SW'(1)) begin
          state_next    = ST_HALT;
          step_cnt_next = '0;
        end else if (sel == PR_RUN) begin
          state_next    = ST_RUN;
          step_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_OFF;
        step_cnt_next = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the transition taken.
  always_comb begin
    ce_next      = (state_next != ST_OFF);
    halted_next  = (state_next == ST_HALT);
    restart_next = (state_next == ST_RUN) &&
                   ((sel == PR_RESTART) || (state == ST_OFF && sel == PR_RUN));
    resume_next  = (state == ST_HALT) && (sel == PR_RUN || sel == PR_STEP);
  end

endmodule

// File: tb/tb_run_control_unit.sv
// Bench for run_control_unit: two instances (STEP_CYCLES 1 and 3) share
// stimulus; directed scenarios use fixed expectations, a randomized phase
// compares against a behavioural model of buttons and run sequencing.
module tb_run_control_unit;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_run = 1'b0, btn_stop = 1'b0, btn_step = 1'b0, btn_restart = 1'b0;
  logic hlt = 1'b0;

  logic ce_a, h_a, res_a, rs_a;
  logic [1:0] st_a;
  logic ce_b, h_b, res_b, rs_b;
  logic [1:0] st_b;
  logic [5:0] obs_a, obs_b;

  // Packed view: {controller_enable, halted, resume, restart, run_state}
  assign obs_a = {ce_a, h_a, res_a, rs_a, st_a};
  assign obs_b = {ce_b, h_b, res_b, rs_b, st_b};

  int errors = 0;
  int checks = 0;

  run_control_unit #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(1)) dut_a (
    .internal_clock(clk), .reset(rst_n),
    .btn_run(btn_run), .btn_stop(btn_stop), .btn_step(btn_step), .btn_restart(btn_restart),
    .hlt_decoded(hlt),
    .controller_enable(ce_a), .halted(h_a), .resume(res_a), .restart(rs_a), .run_state(st_a)
  );

  run_control_unit #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(3)) dut_b (
    .internal_clock(clk), .reset(rst_n),
    .btn_run(btn_run), .btn_stop(btn_stop), .btn_step(btn_step), .btn_restart(btn_restart),
    .hlt_decoded(hlt),
    .controller_enable(ce_b), .halted(h_b), .resume(res_b), .restart(rs_b), .run_state(st_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0] st;
    logic [7:0] left;
    logic       ce;
    logic       h;
    logic       res;
    logic       rs;
  } model_t;

  model_t ma, mb;
  logic [4*(D+2)-1:0] hist;      // raw samples, entry j = sample j edges ago
  logic [4*(D+2)-1:0] hist_now;
  logic [3:0] lvl, rose, pr;     // per button {restart, stop, step, run}

  assign hist_now = {hist[4*(D+1)-1:0], btn_restart, btn_stop, btn_step, btn_run};

  // A level is accepted once the last D synchronized samples (raw delayed by
  // two edges) all disagree with it.
  function automatic logic [7:0] deb_next(logic [3:0] l, logic [4*(D+2)-1:0] h);
    logic [3:0] nl, ro;
    logic flip;
    nl = l;
    ro = '0;
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = 0; k < D; k++)
        if (h[4*(2+k)+b] == l[b]) flip = 1'b0;
      if (flip) begin
        nl[b] = ~l[b];
        ro[b] = ~l[b];
      end
    end
    return {nl, ro};
  endfunction

  // Run-control rules: 0=OFF 1=RUN 2=HALT 3=STEP, one press per cycle wins.
  function automatic model_t fsm_next(model_t m, int sc, logic [3:0] p, logic hl);
    model_t n;
    logic r, s, t, u;
    n = m;
    n.res = 1'b0;
    n.rs = 1'b0;
    r = p[3];
    s = p[2] & ~p[3];
    t = p[1] & ~(p[3] | p[2]);
    u = p[0] & ~(p[3] | p[2] | p[1]);
    case (m.st)
      2'd0: if (r | u) begin n.st = 2'd1; n.rs = 1'b1; end
      2'd1: if (r) n.rs = 1'b1; else if (s | hl) n.st = 2'd2;
      2'd2: begin
        if (r) begin n.st = 2'd1; n.rs = 1'b1; end
        else if (u) begin n.st = 2'd1; n.res = 1'b1; end
        else if (t) begin n.st = 2'd3; n.res = 1'b1; n.left = 8'(sc); end
      end
      default: begin
        n.left = m.left - 8'd1;
        if (r) begin n.st = 2'd1; n.rs = 1'b1; n.left = '0; end
        else if (s | hl | (n.left == 8'd0)) begin n.st = 2'd2; n.left = '0; end
        else if (u) begin n.st = 2'd1; n.left = '0; end
      end
    endcase
    n.ce = (n.st != 2'd0);
    n.h = (n.st == 2'd2);
    return n;
  endfunction

  function automatic logic [5:0] pack(model_t m);
    return {m.ce, m.h, m.res, m.rs, m.st};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      hist <= '0;
      lvl <= '0;
      rose <= '0;
      pr <= '0;
    end else begin
      ma <= fsm_next(ma, 1, pr, hlt);
      mb <= fsm_next(mb, 3, pr, hlt);
      pr <= rose;
      hist <= hist_now;
      {lvl, rose} <= deb_next(lvl, hist_now);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (obs_a !== 6'b000000) begin errors++; $display("FAIL reset_a: got %b expected %b", obs_a, 6'b000000); end
    if (obs_b !== 6'b000000) begin errors++; $display("FAIL reset_b: got %b expected %b", obs_b, 6'b000000); end
    rst_n = 1'b1;
    wait_cycles(3);
    checks += 2;
    if (obs_a !== 6'b000000) begin errors++; $display("FAIL post_reset_a: got %b expected %b", obs_a, 6'b000000); end
    if (obs_b !== 6'b000000) begin errors++; $display("FAIL post_reset_b: got %b expected %b", obs_b, 6'b000000); end
  endtask

  task automatic test_run_start;
    logic [5:0] exp;
    btn_run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i < 8) ? 6'b000000 : (i == 8) ? 6'b100101 : 6'b100001;
      checks += 2;
      if (obs_a !== exp) begin errors++; $display("FAIL run_start_a cyc %0d: got %b expected %b", i, obs_a, exp); end
      if (obs_b !== exp) begin errors++; $display("FAIL run_start_b cyc %0d: got %b expected %b", i, obs_b, exp); end
    end
    btn_run = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_stop;
    logic [5:0] exp;
    btn_stop = 1'b1;
    wait_cycles(2);
    btn_stop = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (obs_a !== 6'b100001) begin errors++; $display("FAIL stop_glitch_a cyc %0d: got %b expected %b", i, obs_a, 6'b100001); end
      if (obs_b !== 6'b100001) begin errors++; $display("FAIL stop_glitch_b cyc %0d: got %b expected %b", i, obs_b, 6'b100001); end
    end
    btn_stop = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i < 8) ? 6'b100001 : 6'b110010;
      checks += 2;
      if (obs_a !== exp) begin errors++; $display("FAIL stop_held_a cyc %0d: got %b expected %b", i, obs_a, exp); end
      if (obs_b !== exp) begin errors++; $display("FAIL stop_held_b cyc %0d: got %b expected %b", i, obs_b, exp); end
    end
    btn_stop = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_step;
    logic [5:0] ea, eb;
    btn_step = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      ea = (i == 8) ? 6'b101011 : 6'b110010;
      eb = (i == 8) ? 6'b101011 : (i == 9 || i == 10) ? 6'b100011 : 6'b110010;
      checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL step1_a cyc %0d: got %b expected %b", i, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL step3_b cyc %0d: got %b expected %b", i, obs_b, eb); end
      if (i == 10) btn_step = 1'b0;
    end
    wait_cycles(8);
  endtask

  task automatic test_hlt_resume;
    logic [5:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      btn_run = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        exp = (i < 8) ? 6'b110010 : (i == 8) ? 6'b101001 : 6'b100001;
        checks += 2;
        if (obs_a !== exp) begin errors++; $display("FAIL resume%0d_a cyc %0d: got %b expected %b", pass, i, obs_a, exp); end
        if (obs_b !== exp) begin errors++; $display("FAIL resume%0d_b cyc %0d: got %b expected %b", pass, i, obs_b, exp); end
      end
      btn_run = 1'b0;
      wait_cycles(10);
      hlt = 1'b1;
      @(negedge clk);
      hlt = 1'b0;
      checks += 2;
      if (obs_a !== 6'b110010) begin errors++; $display("FAIL hlt%0d_a: got %b expected %b", pass, obs_a, 6'b110010); end
      if (obs_b !== 6'b110010) begin errors++; $display("FAIL hlt%0d_b: got %b expected %b", pass, obs_b, 6'b110010); end
    end
  endtask

  task automatic test_restart_stop;
    logic [5:0] exp;
    btn_restart = 1'b1;
    btn_stop = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i < 8) ? 6'b110010 : (i == 8) ? 6'b100101 : 6'b100001;
      checks += 2;
      if (obs_a !== exp) begin errors++; $display("FAIL restart_stop_a cyc %0d: got %b expected %b", i, obs_a, exp); end
      if (obs_b !== exp) begin errors++; $display("FAIL restart_stop_b cyc %0d: got %b expected %b", i, obs_b, exp); end
    end
    btn_restart = 1'b0;
    btn_stop = 1'b0;
    wait_cycles(10);
    checks += 2;
    if (obs_a !== 6'b100001) begin errors++; $display("FAIL restart_stop_after_a: got %b expected %b", obs_a, 6'b100001); end
    if (obs_b !== 6'b100001) begin errors++; $display("FAIL restart_stop_after_b: got %b expected %b", obs_b, 6'b100001); end
  endtask

  task automatic test_reset_mid_step;
    logic [5:0] exp;
    hlt = 1'b1;
    @(negedge clk);
    hlt = 1'b0;
    btn_step = 1'b1;
    wait_cycles(9);
    checks += 1;
    if (obs_b !== 6'b100011) begin errors++; $display("FAIL mid_step_b: got %b expected %b", obs_b, 6'b100011); end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (obs_a !== 6'b000000) begin errors++; $display("FAIL async_reset_a: got %b expected %b", obs_a, 6'b000000); end
    if (obs_b !== 6'b000000) begin errors++; $display("FAIL async_reset_b: got %b expected %b", obs_b, 6'b000000); end
    btn_step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    btn_step = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (obs_a !== 6'b000000) begin errors++; $display("FAIL off_step_a cyc %0d: got %b expected %b", i, obs_a, 6'b000000); end
      if (obs_b !== 6'b000000) begin errors++; $display("FAIL off_step_b cyc %0d: got %b expected %b", i, obs_b, 6'b000000); end
    end
    btn_step = 1'b0;
    wait_cycles(10);
    btn_restart = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp = (i < 8) ? 6'b000000 : (i == 8) ? 6'b100101 : 6'b100001;
      checks += 2;
      if (obs_a !== exp) begin errors++; $display("FAIL off_restart_a cyc %0d: got %b expected %b", i, obs_a, exp); end
      if (obs_b !== exp) begin errors++; $display("FAIL off_restart_b cyc %0d: got %b expected %b", i, obs_b, exp); end
    end
    btn_restart = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_random;
    int hold [4];
    logic [3:0] lv;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs_a !== pack(ma)) begin errors++; $display("FAIL random_a cyc %0d: got %b expected %b", c, obs_a, pack(ma)); end
      if (obs_b !== pack(mb)) begin errors++; $display("FAIL random_b cyc %0d: got %b expected %b", c, obs_b, pack(mb)); end
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lv[b] = ($urandom_range(0, 3) == 0);
          hold[b] = lv[b] ? int'($urandom_range(1, 12)) : int'($urandom_range(2, 25));
        end else begin
          hold[b]--;
        end
      end
      {btn_restart, btn_stop, btn_step, btn_run} = lv;
      hlt = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (obs_a !== 6'b000000) begin errors++; $display("FAIL random_reset_a cyc %0d: got %b expected %b", c, obs_a, 6'b000000); end
        if (obs_b !== 6'b000000) begin errors++; $display("FAIL random_reset_b cyc %0d: got %b expected %b", c, obs_b, 6'b000000); end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    {btn_restart, btn_stop, btn_step, btn_run} = 4'b0000;
    hlt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_stop();
    test_step();
    test_hlt_resume();
    test_restart_stop();
    test_reset_mid_step();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
